// File: rtl/mul_wb_buffer.sv
// mul_wb_buffer: result buffer between the non-stalling multiplier and writeback.
// Every completed product is captured in a circular FIFO and held until the
// writeback stage takes it via the wb_done/wb_accepted handshake. A credit
// counter (in-flight ops + buffered entries) gates new issues so the buffer
// can never overflow.
//
// Ports:
//   clk, rst               clock; synchronous active-low reset
//   issue_new_request      op enters the multiplier (consumes one credit)
//   issue_ready            credit available
//   mul_valid/mul_id/mul_rd  single-cycle result strobe from the multiplier
//   wb_done/wb_id/wb_rd    head result presented to writeback
//   wb_accepted            writeback takes the head (only while wb_done=1)
//   occupancy              number of buffered entries (debug/perf)
//
// Optional feature: define MUL_WB_BYPASS_EN to forward a result straight from
// mul_* to wb_* in the same cycle when the buffer is empty (0-cycle latency).
// Without it, latency is one cycle and there is no mul_* -> wb_* path.
module mul_wb_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 3,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_new_request,
  output logic                     issue_ready,
  input  logic                     mul_valid,
  input  logic [ID_W-1:0]          mul_id,
  input  logic [XLEN-1:0]          mul_rd,
  output logic                     wb_done,
  output logic [ID_W-1:0]          wb_id,
  output logic [XLEN-1:0]          wb_rd,
  input  logic                     wb_accepted,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] rd;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  entry_t             head;
  logic               buf_valid;
  logic               bypass;
  logic               push;
  logic               pop;

  // Writeback presentation: head entry, or the live multiplier result when bypassing.
  always_comb begin
    buf_valid = (count_q != '0);
    head      = mem_q[rd_ptr_q];
    bypass    = 1'b0;
    wb_done   = buf_valid;
    wb_id     = head.id;
    wb_rd     = head.rd;
`ifdef MUL_WB_BYPASS_EN
    if (!buf_valid && mul_valid) begin
      bypass  = 1'b1;
      wb_done = 1'b1;
      wb_id   = mul_id;
      wb_rd   = mul_rd;
    end
`endif
  end

  // A bypassed result accepted in the same cycle never touches the FIFO.
  always_comb begin
    pop  = wb_accepted && buf_valid;
    push = mul_valid && !(bypass && wb_accepted);
  end

  // Sum is one bit wider so inflight + count cannot wrap before the compare.
  always_comb begin
    issue_ready = ((SUM_W'(inflight_q) + SUM_W'(count_q)) < SUM_W'(DEPTH));
    occupancy   = count_q;
  end

  // Next-state for FIFO storage, pointers and counters.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    inflight_d = inflight_q + CNT_W'(issue_new_request) - CNT_W'(mul_valid);
    if (push) begin
      mem_d[wr_ptr_q] = '{id: mul_id, rd: mul_rd};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // State registers; storage is cleared too so wb_id/wb_rd read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // Protocol checks on the surrounding pipeline.
  always @(posedge clk) begin
    if (rst) begin
      a_overflow: assert (!(mul_valid && (count_q == CNT_W'(DEPTH)) && !pop))
        else $error("mul_wb_buffer: result overflow");
      a_spurious_accept: assert (!(wb_accepted && !wb_done))
        else $error("mul_wb_buffer: accept without done");
      a_credit: assert (!(issue_new_request && !issue_ready))
        else $error("mul_wb_buffer: issue without credit");
      a_inflight_underflow: assert (!(mul_valid && (inflight_q == '0)))
        else $error("mul_wb_buffer: result with nothing in flight");
    end
  end

endmodule

// File: tb/tb_mul_wb_buffer.sv
// tb_mul_wb_buffer: directed and randomised checks for mul_wb_buffer.
// Inputs are driven 1ns after the rising edge and outputs sampled 1ns later.
module tb_mul_wb_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned XLEN  = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    issue_new_request;
  logic                    issue_ready;
  logic                    mul_valid;
  logic [ID_W-1:0]         mul_id;
  logic [XLEN-1:0]         mul_rd;
  logic                    wb_done;
  logic [ID_W-1:0]         wb_id;
  logic [XLEN-1:0]         wb_rd;
  logic                    wb_accepted;
  logic [$clog2(DEPTH):0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  logic [ID_W+XLEN-1:0] refq [$];

  always #5 clk = ~clk;

  mul_wb_buffer #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN)) dut (
    .clk               (clk),
    .rst               (rst),
    .issue_new_request (issue_new_request),
    .issue_ready       (issue_ready),
    .mul_valid         (mul_valid),
    .mul_id            (mul_id),
    .mul_rd            (mul_rd),
    .wb_done           (wb_done),
    .wb_id             (wb_id),
    .wb_rd             (wb_rd),
    .wb_accepted       (wb_accepted),
    .occupancy         (occupancy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_new_request = 1'b0;
    mul_valid         = 1'b0;
    wb_accepted       = 1'b0;
  endtask

  // One cycle: drive issue/result, accept the head if allowed, check it against the reference queue.
  task automatic cyc(input logic iss, input logic mv, input logic [ID_W-1:0] id,
                     input logic [XLEN-1:0] rd, input logic acc_en, output logic acc_o);
    logic [ID_W+XLEN-1:0] exp;
    issue_new_request = iss;
    mul_valid         = mv;
    mul_id            = id;
    mul_rd            = rd;
    if (mv) refq.push_back({id, rd});
    #1;
    wb_accepted = acc_en && wb_done;
    acc_o       = wb_accepted;
    if (wb_accepted) begin
      check("ref_nonempty", 32'(refq.size() != 0), 32'd1);
      if (refq.size() != 0) begin
        exp = refq.pop_front();
        check("order_id", 32'(wb_id), 32'(exp[ID_W+XLEN-1:XLEN]));
        check("order_rd", wb_rd, exp[XLEN-1:0]);
      end
    end
    tick();
    idle();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0]  vals [4];
    logic             acc;
    logic             p_v  [2];
    logic [ID_W-1:0]  p_id [2];
    logic [XLEN-1:0]  p_rd [2];
    int               issued, delivered, cycles, wait_n, max_occ;
    logic             iss;

    vals[0] = 32'h0000_0001;
    vals[1] = 32'h0000_0015;
    vals[2] = 32'hffff_ffff;
    vals[3] = 32'h0000_ff7f;

    // Reset state
    rst = 1'b0; idle(); mul_id = '0; mul_rd = '0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rst_done", 32'(wb_done), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_id", 32'(wb_id), 32'd0);
    check("rst_rd", wb_rd, 32'd0);

    // Single result
    issue_new_request = 1'b1; tick(); issue_new_request = 1'b0;
    mul_valid = 1'b1; mul_id = 3'd2; mul_rd = 32'h0000_1200;
    #1;
`ifdef MUL_WB_BYPASS_EN
    check("single_bypass_done", 32'(wb_done), 32'd1);
    check("single_bypass_id", 32'(wb_id), 32'd2);
    check("single_bypass_rd", wb_rd, 32'h0000_1200);
`else
    check("single_no_early_done", 32'(wb_done), 32'd0);
`endif
    tick(); mul_valid = 1'b0; #1;
    check("single_done", 32'(wb_done), 32'd1);
    check("single_id", 32'(wb_id), 32'd2);
    check("single_rd", wb_rd, 32'h0000_1200);
    wb_accepted = 1'b1; tick(); wb_accepted = 1'b0; #1;
    check("single_drained", 32'(wb_done), 32'd0);
    check("single_ready", 32'(issue_ready), 32'd1);

    // Fill to capacity
    for (int i = 0; i < 4; i++) begin
      check("fill_ready_pre", 32'(issue_ready), 32'd1);
      issue_new_request = 1'b1; tick(); issue_new_request = 1'b0;
    end
    #1;
    check("fill_ready_full", 32'(issue_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      mul_valid = 1'b1; mul_id = ID_W'(i + 1); mul_rd = vals[i];
      tick();
    end
    mul_valid = 1'b0; #1;
    check("fill_occ", 32'(occupancy), 32'd4);
    check("fill_ready_held", 32'(issue_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("fill_id", 32'(wb_id), 32'(i + 1));
      check("fill_rd", wb_rd, vals[i]);
      wb_accepted = 1'b1; tick(); wb_accepted = 1'b0; #1;
      if (i == 0) check("fill_ready_after_accept", 32'(issue_ready), 32'd1);
    end
    check("fill_empty", 32'(occupancy), 32'd0);

    // Simultaneous push and pop at count=1
    issue_new_request = 1'b1; tick(); tick(); issue_new_request = 1'b0;
    mul_valid = 1'b1; mul_id = 3'd5; mul_rd = 32'h0000_000a;
    tick(); mul_valid = 1'b0; #1;
    check("pp_occ_pre", 32'(occupancy), 32'd1);
    mul_valid = 1'b1; mul_id = 3'd6; mul_rd = 32'h0000_000b; wb_accepted = 1'b1;
    #1;
    check("pp_head_old", 32'(wb_id), 32'd5);
    tick(); idle(); #1;
    check("pp_occ", 32'(occupancy), 32'd1);
    check("pp_head_id", 32'(wb_id), 32'd6);
    check("pp_head_rd", wb_rd, 32'h0000_000b);
    wb_accepted = 1'b1; tick(); wb_accepted = 1'b0; #1;
    check("pp_empty", 32'(occupancy), 32'd0);

    // Reset mid-operation: occupancy=3, inflight=1
    issue_new_request = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    issue_new_request = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mul_valid = 1'b1; mul_id = ID_W'(i); mul_rd = 32'h100 + 32'(i);
      tick();
    end
    mul_valid = 1'b0; #1;
    check("mid_occ_pre", 32'(occupancy), 32'd3);
    check("mid_infl_pre", 32'(dut.inflight_q), 32'd1);
    rst = 1'b0; mul_valid = 1'b1; mul_id = 3'd7; issue_new_request = 1'b1;
    tick(); rst = 1'b1; idle(); #1;
    check("mid_done", 32'(wb_done), 32'd0);
    check("mid_occ", 32'(occupancy), 32'd0);
    check("mid_ready", 32'(issue_ready), 32'd1);
    issue_new_request = 1'b1; tick(); issue_new_request = 1'b0;
    mul_valid = 1'b1; mul_id = 3'd1; mul_rd = 32'h0000_cafe;
    tick(); mul_valid = 1'b0; #1;
    check("mid_fresh_id", 32'(wb_id), 32'd1);
    check("mid_fresh_rd", wb_rd, 32'h0000_cafe);
    wb_accepted = 1'b1; tick(); wb_accepted = 1'b0; #1;
    check("mid_fresh_drained", 32'(occupancy), 32'd0);

    // Inflight accounting: issue and result together with continuous accepts
    cyc(1'b1, 1'b0, '0, '0, 1'b0, acc);
    for (int k = 0; k < 20; k++) begin
      check("infl_ready", 32'(issue_ready), 32'd1);
      check("infl_count", 32'(dut.inflight_q), 32'd1);
      cyc(1'b1, 1'b1, ID_W'(k), 32'(k * 3 + 7), 1'b1, acc);
    end
    cyc(1'b0, 1'b1, 3'd3, 32'h5a5a_0000, 1'b1, acc);
    for (int k = 0; k < 8; k++) begin
      if (occupancy != 0) cyc(1'b0, 1'b0, '0, '0, 1'b1, acc);
    end
    check("infl_drained_occ", 32'(occupancy), 32'd0);
    check("infl_drained_cnt", 32'(dut.inflight_q), 32'd0);

    // Pointer wrap: 1000 random results, 2-cycle multiplier, 0-15 cycle accept delay
    for (int s = 0; s < 2; s++) begin
      p_v[s] = 1'b0; p_id[s] = '0; p_rd[s] = '0;
    end
    issued = 0; delivered = 0; cycles = 0; max_occ = 0;
    wait_n = $urandom_range(0, 15);
    while (delivered < 1000 && cycles < 40000) begin
      iss = issue_ready && (issued < 1000) && ($urandom_range(0, 1) == 1);
      cyc(iss, p_v[1], p_id[1], p_rd[1], (wait_n == 0), acc);
      p_v[1] = p_v[0]; p_id[1] = p_id[0]; p_rd[1] = p_rd[0];
      p_v[0] = iss; p_id[0] = ID_W'($urandom_range(0, 7)); p_rd[0] = $urandom;
      if (iss) issued++;
      if (acc) begin
        delivered++;
        wait_n = $urandom_range(0, 15);
      end else if (wb_done && wait_n > 0) begin
        wait_n--;
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      cycles++;
    end
    check("rand_delivered", 32'(delivered), 32'd1000);
    check("rand_max_occ_ok", 32'(max_occ <= 4), 32'd1);
    check("rand_ref_empty", 32'(refq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_wb_buffer.md
Name: mul_wb_buffer

Overview:
- Result buffer directly downstream of the multiplier unit.
- The multiplier pipeline cannot stall, so every completed product is captured here and held until the writeback stage accepts it via the done/accepted handshake.
- A credit scheme holds back new issues to the multiplier, so the in-flight products plus the buffered entries never exceed the buffer capacity.

Parameters:
- DEPTH, 4, number of result entries; power of two, at least 2.
- ID_W, 3, width of the instruction ID carried with each result.
- XLEN, 32, result data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low. When rst=0 at a rising edge, all state is cleared.
- issue_new_request  in  1  a new op enters the multiplier this cycle; consumes one credit.
- issue_ready  out  1  a credit is available; the issue stage may assert issue_new_request.
- mul_valid  in  1  the multiplier produced a result this cycle; this is a single-cycle strobe.
- mul_id  in  ID_W  ID of the produced result.
- mul_rd  in  XLEN  produced result data.
- wb_done  out  1  the head result is presented to writeback.
- wb_id  out  ID_W  ID of the head result.
- wb_rd  out  XLEN  data of the head result.
- wb_accepted  in  1  writeback takes the head this cycle. Legal only while wb_done=1.
- occupancy  out  $clog2(DEPTH)+1  number of buffered entries; debug/perf output.

Behaviour:
- Storage: circular FIFO of DEPTH entries {id, rd}.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - Count register is $clog2(DEPTH)+1 bits wide.
- Push: on mul_valid=1, write {mul_id, mul_rd} at the write pointer and increment the write pointer.
- Pop: on wb_accepted=1 with wb_done=1, increment the read pointer.
- Simultaneous push and pop: both pointers advance and the count is unchanged. This is legal at any count, including count=DEPTH-1 and count=DEPTH when a pop is present.
- In-flight counter:
  - inflight is $clog2(DEPTH)+1 bits.
  - Increment on issue_new_request; decrement on mul_valid.
  - Both in the same cycle: unchanged.
- Credit output: issue_ready = (inflight + count) < DEPTH. This is combinational from registered state only, with no path from issue_new_request or wb_accepted.
- Outputs without the bypass feature:
  - wb_done = (count != 0).
  - wb_id / wb_rd = the head entry.
  - A result pushed in cycle N is visible on wb_done in cycle N+1 at the earliest. Latency is 1 cycle.
- Ordering: results are delivered strictly in push order.
- Reset (rst=0 at the edge), including mid-operation:
  - Pointers, count and inflight go to 0.
  - wb_done=0, issue_ready=1, occupancy=0.
  - wb_id and wb_rd go to 0.
  - Any in-flight multiplier results are discarded. The multiplier is reset in the same cycle.
  - Inputs are ignored while rst=0.
- Error conditions (simulation assertions, not RTL recovery):
  - mul_valid while count=DEPTH and no pop: overflow.
  - wb_accepted while wb_done=0: spurious accept.
  - issue_new_request while issue_ready=0: credit violation.
  - mul_valid while inflight=0: inflight underflow.

Optional Feature:
- Macro: MUL_WB_BYPASS_EN.
- When defined, with count=0 and mul_valid=1:
  - wb_done=1 in the same cycle, with wb_id=mul_id and wb_rd=mul_rd driven combinationally. Latency is 0 cycles.
  - If wb_accepted=1 in that cycle, the entry is not written and count stays 0.
  - Otherwise the entry is written as a normal push.
- When count>0, behaviour is identical to the non-bypass build.
- When not defined: there is no combinational path from the mul_* inputs to the wb_* outputs, and latency is 1 cycle.

Test Plan:
- Reset, then a single result:
  - Stimulus: issue 1 op; mul_valid with id=2, rd=0x00001200; wb_accepted the cycle after done.
  - Required response: wb_done rises 1 cycle after mul_valid (0 cycles with the bypass), wb_id=2, wb_rd=0x00001200; after the accept, wb_done=0 and issue_ready=1.
- Fill to capacity (DEPTH=4):
  - Stimulus: 4 issues with no accepts.
  - Required response: issue_ready=0 after the 4th issue.
  - Stimulus: 4 results, rd=0x1, 0x15, 0xffffffff, 0x0000ff7f.
  - Required response: occupancy=4; accepts return the values in that order; issue_ready returns to 1 after the first accept.
- Simultaneous push and pop at count=1:
  - Stimulus: mul_valid and wb_accepted in the same cycle.
  - Required response: occupancy stays 1 and the head advances to the new entry.
- Pointer wrap:
  - Stimulus: 1000 random results with random accept delay of 0–15 cycles.
  - Required response: all rd/id values match a reference queue in order; occupancy never exceeds 4; no assertion fires.
- Reset mid-operation:
  - Stimulus: rst=0 with occupancy=3 and inflight=1.
  - Required response: next cycle wb_done=0, occupancy=0, issue_ready=1; a fresh result after reset is delivered correctly.
- Inflight accounting:
  - Stimulus: issue_new_request and mul_valid in the same cycle for 20 cycles, with continuous accepts.
  - Required response: issue_ready stays 1 throughout and inflight stays constant.
